pwm_capture: RTL and testbench

//  PWM input decoder. Measures period, high time and integer duty cycle (0..100 %) of an external PWM line.

---
 rtl/pwm_capture.sv | 174 +++++++++++++++++
 tb/tb_pwm_capture.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// pwm_capture: PWM input decoder. Measures period, high time and integer
// duty cycle (floor(high*100/period)) of an asynchronous PWM line and
// reports each result with a one-cycle valid strobe plus held registers.
`timescale 1ns/1ps
module pwm_capture #(
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 5000
) (
  input  logic             clk,
  input  logic             rst_i,
  input  logic             pwm_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_cnt_o,
  output logic [6:0]       duty_o,
  output logic             valid_o,
  output logic             timeout_o,
  output logic             overrun_o
);

  localparam int unsigned      NW      = CNT_W + 7;
  localparam int unsigned      IW      = $clog2(NW + 1);
  localparam logic [CNT_W-1:0] TMO     = CNT_W'(TIMEOUT);
  localparam logic [IW-1:0]    ITER    = IW'(NW);
  localparam logic [NW-1:0]    HUNDRED = NW'(100);

  typedef enum logic [1:0] {WAIT_EDGE, MEASURE, STATIC} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_pwm;
  logic                   s_pwm_d;
  logic                   rise;
  logic [CNT_W-1:0]       per_cnt;
  logic [CNT_W-1:0]       hi_cnt;
  logic                   timeout_hit;
  logic                   stat_pend;

  logic                   busy;
  logic [IW-1:0]          iter_q;
  logic [CNT_W-1:0]       rem_q;
  logic [NW-1:0]          quo_q;
  logic [CNT_W-1:0]       den_q;
  logic [CNT_W-1:0]       cap_per;
  logic [CNT_W-1:0]       cap_hi;

  logic [CNT_W:0]         rem_sh;
  logic [CNT_W:0]         rem_diff;
  logic                   q_bit;
  logic [CNT_W-1:0]       rem_nxt;
  logic [NW-1:0]          quo_nxt;

  assign s_pwm       = sync_q[SYNC_STAGES-1];
  assign rise        = s_pwm & ~s_pwm_d;
  assign timeout_hit = (state != STATIC) && (per_cnt == TMO) && !rise;

  // Synchroniser chain and edge-detect register for the asynchronous input
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      sync_q  <= '0;
      s_pwm_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_i};
      s_pwm_d <= s_pwm;
    end
  end

  // Period and high-time counters: restart on rise, saturate at TIMEOUT
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else if (rise) begin
      per_cnt <= CNT_W'(1);
      hi_cnt  <= CNT_W'(1);
    end else begin
      if (per_cnt != TMO) per_cnt <= per_cnt + 1'b1;
      if (s_pwm && hi_cnt != TMO) hi_cnt <= hi_cnt + 1'b1;
    end
  end

  // One restoring-division step: the borrow of the trial subtraction decides the quotient bit
  always_comb begin
    rem_sh   = {rem_q, quo_q[NW-1]};
    rem_diff = rem_sh - {1'b0, den_q};
    q_bit    = ~rem_diff[CNT_W];
    rem_nxt  = q_bit ? rem_diff[CNT_W-1:0] : rem_sh[CNT_W-1:0];
    quo_nxt  = {quo_q[NW-2:0], q_bit};
  end

  // FSM, divider sequencing and registered result outputs
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state      <= WAIT_EDGE;
      stat_pend  <= 1'b0;
      busy       <= 1'b0;
      iter_q     <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      den_q      <= '0;
      cap_per    <= '0;
      cap_hi     <= '0;
      period_o   <= '0;
      high_cnt_o <= '0;
      duty_o     <= '0;
      valid_o    <= 1'b0;
      timeout_o  <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      valid_o <= 1'b0;

      // The last iteration writes the outputs straight from the final quotient
      // so the result lands on the same edge the divider goes idle.
      if (busy) begin
        rem_q  <= rem_nxt;
        quo_q  <= quo_nxt;
        iter_q <= iter_q - 1'b1;
        if (iter_q == IW'(1)) begin
          busy       <= 1'b0;
          period_o   <= cap_per;
          high_cnt_o <= cap_hi;
          duty_o     <= quo_nxt[6:0];
          valid_o    <= 1'b1;
        end
      end

      // A timeout seen while the divider is busy is held until the division's
      // own strobe has gone out, so the static report follows one cycle later.
      if ((timeout_hit || stat_pend) && !busy) begin
        period_o   <= '0;
        high_cnt_o <= '0;
        duty_o     <= s_pwm ? 7'd100 : 7'd0;
        valid_o    <= 1'b1;
        timeout_o  <= 1'b1;
        stat_pend  <= 1'b0;
      end else if (timeout_hit) begin
        stat_pend <= 1'b1;
      end

      case (state)
        WAIT_EDGE: begin
          if (rise) state <= MEASURE;
          else if (timeout_hit) state <= STATIC;
        end
        MEASURE: begin
          if (rise) begin
            if (busy) begin
              overrun_o <= 1'b1;
            end else begin
              busy    <= 1'b1;
              iter_q  <= ITER;
              rem_q   <= '0;
              quo_q   <= NW'(hi_cnt) * HUNDRED;
              den_q   <= per_cnt;
              cap_per <= per_cnt;
              cap_hi  <= hi_cnt;
            end
          end else if (timeout_hit) begin
            state <= STATIC;
          end
        end
        STATIC: begin
          if (rise) begin
            state     <= MEASURE;
            timeout_o <= 1'b0;
            stat_pend <= 1'b0;
          end
        end
        default: state <= WAIT_EDGE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed and randomized PWM waveforms checked against an
// arithmetic reference (period, high time, floor duty, fixed result latency).
`timescale 1ns/1ps
module tb_pwm_capture;

  localparam int CNT_W       = 16;
  localparam int SYNC_STAGES = 2;
  localparam int TIMEOUT     = 5000;
  // drive cycle of a rise -> strobe: synchroniser + (load + CNT_W+7 steps)
  localparam int LAT         = SYNC_STAGES + CNT_W + 8;

  logic             clk;
  logic             rst_i;
  logic             pwm_i;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_cnt_o;
  logic [6:0]       duty_o;
  logic             valid_o;
  logic             timeout_o;
  logic             overrun_o;

  pwm_capture #(
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk       (clk),
    .rst_i     (rst_i),
    .pwm_i     (pwm_i),
    .period_o  (period_o),
    .high_cnt_o(high_cnt_o),
    .duty_o    (duty_o),
    .valid_o   (valid_o),
    .timeout_o (timeout_o),
    .overrun_o (overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int per;
    int hi;
    int duty;
  } ev_t;

  ev_t  ev_q[$];
  int   cyc      = 0;
  int   passed   = 0;
  int   total    = 0;
  int   to_fall  = -1;
  logic to_prev  = 1'b0;
  logic x_seen   = 1'b0;

  task automatic check(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One clock: sample just after the edge, log strobes and timeout falls
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if ((^{period_o, high_cnt_o, duty_o, valid_o, timeout_o, overrun_o}) === 1'bx)
      x_seen = 1'b1;
    if (valid_o === 1'b1)
      ev_q.push_back('{cyc, int'(period_o), int'(high_cnt_o), int'(duty_o)});
    if (to_prev === 1'b1 && timeout_o === 1'b0) to_fall = cyc;
    to_prev = timeout_o;
  endtask

  task automatic do_reset(input string tag);
    pwm_i = 1'b0;
    rst_i = 1'b1;
    repeat (3) tick();
    check({tag, "_rst_out"}, {period_o, high_cnt_o, duty_o, valid_o, timeout_o, overrun_o}, 0);
    rst_i = 1'b0;
    ev_q.delete();
    x_seen  = 1'b0;
    to_fall = -1;
  endtask

  task automatic run_pwm(input int p, input int h, input int n, output int first_rise);
    first_rise = cyc;
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++) begin
        pwm_i = (i < h);
        tick();
      end
    pwm_i = 1'b0;
  endtask

  function automatic int duty_of(input int h, input int p);
    return (h * 100) / p;
  endfunction

  initial begin
    int r, r2, c_rel, p, h;
    pwm_i = 1'b0;
    rst_i = 1'b1;
    #2;

    // 1: period 1000, high 300, five periods
    do_reset("t1");
    run_pwm(1000, 300, 5, r);
    check("t1_count", ev_q.size(), 4);
    foreach (ev_q[i]) begin
      check("t1_time", ev_q[i].cyc, r + (i + 1) * 1000 + LAT);
      check("t1_per",  ev_q[i].per, 1000);
      check("t1_hi",   ev_q[i].hi, 300);
      check("t1_duty", ev_q[i].duty, duty_of(300, 1000));
    end
    check("t1_overrun", overrun_o, 0);

    // 2: period 300 / high 100 (floor 33), then line held high until static
    do_reset("t2");
    run_pwm(300, 100, 4, r);
    check("t2_count", ev_q.size(), 3);
    foreach (ev_q[i]) check("t2_duty", ev_q[i].duty, duty_of(100, 300));
    ev_q.delete();
    r2 = cyc;
    pwm_i = 1'b1;
    repeat (TIMEOUT + 20) tick();
    check("t2b_count", ev_q.size(), 2);
    if (ev_q.size() == 2) begin
      check("t2b_cap_per",  ev_q[0].per, 300);
      check("t2b_cap_time", ev_q[0].cyc, r2 + LAT);
      check("t2b_st_per",   ev_q[1].per, 0);
      check("t2b_st_hi",    ev_q[1].hi, 0);
      check("t2b_st_duty",  ev_q[1].duty, 100);
      check("t2b_st_win",   (ev_q[1].cyc >= r2 + TIMEOUT) && (ev_q[1].cyc <= r2 + TIMEOUT + SYNC_STAGES + 3), 1);
    end
    check("t2b_timeout", timeout_o, 1);

    // 3a: line low from reset
    do_reset("t3a");
    c_rel = cyc;
    repeat (TIMEOUT + 20) tick();
    check("t3a_count", ev_q.size(), 1);
    if (ev_q.size() == 1) begin
      check("t3a_per",  ev_q[0].per, 0);
      check("t3a_duty", ev_q[0].duty, 0);
      check("t3a_win",  (ev_q[0].cyc >= c_rel + TIMEOUT) && (ev_q[0].cyc <= c_rel + TIMEOUT + 4), 1);
    end
    check("t3a_timeout", timeout_o, 1);

    // 3b: one rise then held high: no capture, static report with 100 %
    do_reset("t3b");
    repeat (5) tick();
    r = cyc;
    pwm_i = 1'b1;
    repeat (TIMEOUT + 20) tick();
    check("t3b_count", ev_q.size(), 1);
    if (ev_q.size() == 1) begin
      check("t3b_duty", ev_q[0].duty, 100);
      check("t3b_per",  ev_q[0].per, 0);
      check("t3b_win",  (ev_q[0].cyc >= r + TIMEOUT) && (ev_q[0].cyc <= r + TIMEOUT + SYNC_STAGES + 3), 1);
    end
    check("t3b_timeout", timeout_o, 1);

    // 4: period 10, high 5: faster than the divider
    do_reset("t4");
    run_pwm(10, 5, 30, r);
    repeat (40) tick();
    check("t4_overrun", overrun_o, 1);
    check("t4_nox", x_seen, 0);
    check("t4_some", ev_q.size() > 0, 1);
    if (ev_q.size() > 0) check("t4_first_time", ev_q[0].cyc, r + 10 + LAT);
    foreach (ev_q[i]) begin
      check("t4_duty", ev_q[i].duty, 50);
      check("t4_per",  ev_q[i].per, 10);
    end

    // 5: reset ten cycles into a division
    do_reset("t5");
    run_pwm(100, 30, 2, r);
    check("t5_pre_count", ev_q.size(), 1);
    check("t5_pre_duty", duty_o, 30);
    ev_q.delete();
    pwm_i = 1'b1;
    repeat (SYNC_STAGES + 1 + 10) tick();
    check("t5_busy_novalid", ev_q.size(), 0);
    rst_i = 1'b1;
    #1;
    check("t5_async_zero", {period_o, high_cnt_o, duty_o, valid_o}, 0);
    pwm_i = 1'b0;
    repeat (3) tick();
    rst_i = 1'b0;
    repeat (40) tick();
    check("t5_discarded", ev_q.size(), 0);
    run_pwm(150, 60, 3, r);
    repeat (40) tick();
    check("t5_count", ev_q.size(), 2);
    if (ev_q.size() > 0) begin
      check("t5_first_time", ev_q[0].cyc, r + 150 + LAT);
      check("t5_duty", ev_q[0].duty, duty_of(60, 150));
    end

    // 6: timeout, then resume at period 200 / high 50
    do_reset("t6");
    repeat (TIMEOUT + 20) tick();
    check("t6_timeout", timeout_o, 1);
    ev_q.delete();
    to_fall = -1;
    run_pwm(200, 50, 3, r);
    repeat (40) tick();
    check("t6_to_fall", to_fall, r + SYNC_STAGES + 1);
    check("t6_count", ev_q.size(), 2);
    if (ev_q.size() > 0) begin
      check("t6_time", ev_q[0].cyc, r + 200 + LAT);
      check("t6_duty", ev_q[0].duty, 25);
      check("t6_hi",   ev_q[0].hi, 50);
    end

    // 7: random period/high pairs slow enough to avoid overrun
    for (int t = 0; t < 5; t++) begin
      do_reset("t7");
      p = int'($urandom_range(400, 30));
      h = int'($urandom_range(p - 1, 1));
      run_pwm(p, h, 3, r);
      repeat (40) tick();
      check("t7_count", ev_q.size(), 2);
      foreach (ev_q[i]) begin
        check("t7_time", ev_q[i].cyc, r + (i + 1) * p + LAT);
        check("t7_per",  ev_q[i].per, p);
        check("t7_hi",   ev_q[i].hi, h);
        check("t7_duty", ev_q[i].duty, duty_of(h, p));
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
